// File: rtl/sccb_config_if.sv
// SCCB configuration master bus bundle: start request, SIOC/SIOD drive and status.
interface sccb_config_if;
   logic start;
   logic sioc;
   logic siod_out;
   logic siod_oe;
   logic busy;
   logic done;

   modport master (
      input  start,
      output sioc, siod_out, siod_oe, busy, done
   );

   modport slave (
      output start,
      input  sioc, siod_out, siod_oe, busy, done
   );
endinterface

// File: rtl/sccb_config.sv
// OV7670 register-configuration master: waits out sensor power-up, then writes a
// fixed 6-entry register table as SCCB 3-phase writes. Soft reset (entry 0) is
// followed by an extra settle delay. All bus outputs are registered.
module sccb_config #(
   parameter int         QDIV     = 60,
   parameter int         PWR_WAIT = 24000,
   parameter int         RST_WAIT = 24000,
   parameter logic [7:0] DEV_ADDR = 8'h42
) (
   input  logic          clk_24,
   input  logic          reset_n,
   sccb_config_if.master bus
);
   localparam int              NUM_REGS = 6;
   localparam int              WMAX     = (PWR_WAIT > RST_WAIT) ? PWR_WAIT : RST_WAIT;
   localparam int              WW       = $clog2(WMAX + 1);
   localparam logic [6:0]      TMAX     = 7'(QDIV - 1);
   localparam logic [WW-1:0]   PWR_LAST = WW'(PWR_WAIT - 1);
   localparam logic [WW-1:0]   RST_LAST = WW'(RST_WAIT - 1);
   localparam logic [2:0]      IDX_LAST = 3'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_WAIT_PWR, S_START, S_BITS, S_STOP, S_GAP, S_RST_DLY, S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [6:0]    tcnt_q, tcnt_d;
   logic [1:0]    qph_q, qph_d;
   logic [4:0]    bit_q, bit_d;
   logic [2:0]    idx_q, idx_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          sioc_q, sioc_d;
   logic          siod_q, siod_d;
   logic          oe_q, oe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          tick;
   logic          bus_st;
   logic [7:0]    sub_addr, sub_data;
   logic [26:0]   frame;
   logic [4:0]    bsel;
   logic          dc_bit;

   // Register table lookup for the entry currently being written
   always_comb begin
      sub_addr = 8'h00;
      sub_data = 8'h00;
      case (idx_q)
         3'd0:    begin sub_addr = 8'h12; sub_data = 8'h80; end // soft reset
         3'd1:    begin sub_addr = 8'h12; sub_data = 8'h00; end // YUV output
         3'd2:    begin sub_addr = 8'h11; sub_data = 8'h01; end // PCLK prescale /2
         3'd3:    begin sub_addr = 8'h0C; sub_data = 8'h00; end
         3'd4:    begin sub_addr = 8'h3A; sub_data = 8'h04; end // YUYV order
         3'd5:    begin sub_addr = 8'h40; sub_data = 8'hC0; end // full-range output
         default: begin sub_addr = 8'h00; sub_data = 8'h00; end
      endcase
   end

   // The three-phase frame, MSB first; the ninth bit of each phase is released
   assign frame  = {DEV_ADDR, 1'b1, sub_addr, 1'b1, sub_data, 1'b1};
   assign bsel   = 5'd26 - bit_q;
   assign dc_bit = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);
   assign tick   = (tcnt_q == TMAX);
   assign bus_st = state_q inside {S_START, S_BITS, S_STOP, S_GAP};

   // Next-state and bus-output logic; bus changes happen only on a tick
   always_comb begin
      state_d = state_q;
      tcnt_d  = '0;
      qph_d   = qph_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      sioc_d  = sioc_q;
      siod_d  = siod_q;
      oe_d    = oe_q;

      // Quarter-bit timebase only runs while on the bus, so every transaction
      // starts phase-aligned and lasts exactly 118 ticks.
      if (bus_st) tcnt_d = tick ? 7'd0 : tcnt_q + 7'd1;

      case (state_q)
         S_WAIT_PWR: begin
            if (wait_q == PWR_LAST) begin
               wait_d  = '0;
               qph_d   = 2'd0;
               state_d = S_START;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_START: begin
            if (tick) begin
               if (qph_q == 2'd0) begin
                  siod_d = 1'b0;             // start: SIOD falls with SIOC high
                  qph_d  = 2'd1;
               end else begin
                  sioc_d  = 1'b0;
                  qph_d   = 2'd0;
                  bit_d   = 5'd0;
                  state_d = S_BITS;
               end
            end
         end
         S_BITS: begin
            if (tick) begin
               qph_d = qph_q + 2'd1;
               case (qph_q)
                  2'd0: begin
                     sioc_d = 1'b0;
                     siod_d = dc_bit ? 1'b1 : frame[bsel];
                     oe_d   = ~dc_bit;
                  end
                  2'd1: sioc_d = 1'b1;
                  2'd2: ;                    // hold data past the SIOC rise
                  default: begin
                     sioc_d = 1'b0;
                     if (bit_q == 5'd26) state_d = S_STOP;
                     else                bit_d   = bit_q + 5'd1;
                  end
               endcase
            end
         end
         S_STOP: begin
            if (tick) begin
               qph_d = qph_q + 2'd1;
               case (qph_q)
                  2'd0: begin siod_d = 1'b0; oe_d = 1'b1; end
                  2'd1: sioc_d = 1'b1;
                  2'd2: siod_d = 1'b1;       // stop: SIOD rises with SIOC high
                  default: state_d = S_GAP;
               endcase
            end
         end
         S_GAP: begin
            if (tick) begin
               qph_d = qph_q + 2'd1;
               if (qph_q == 2'd3) begin
                  if (idx_q == IDX_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d   = idx_q + 3'd1;
                     wait_d  = '0;
                     state_d = (idx_q == 3'd0) ? S_RST_DLY : S_START;
                  end
               end
            end
         end
         S_RST_DLY: begin
            if (wait_q == RST_LAST) begin
               wait_d  = '0;
               qph_d   = 2'd0;
               state_d = S_START;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DONE: begin
            if (bus.start) begin
               idx_d   = 3'd0;
               qph_d   = 2'd0;
               state_d = S_START;
            end
         end
         default: state_d = S_WAIT_PWR;
      endcase

      busy_d = (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; reset aborts any transaction immediately
   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_WAIT_PWR;
         tcnt_q  <= '0;
         qph_q   <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         wait_q  <= '0;
         sioc_q  <= 1'b1;
         siod_q  <= 1'b1;
         oe_q    <= 1'b1;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         qph_q   <= qph_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         sioc_q  <= sioc_d;
         siod_q  <= siod_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.sioc     = sioc_q;
   assign bus.siod_out = siod_q;
   assign bus.siod_oe  = oe_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_sccb_config.sv
// Directed bench for sccb_config: bus monitor decodes start/stop/bits from the
// pins, main thread steps through reset, full table run, and restart from DONE.
module tb_sccb_config;
   localparam int QDIV = 2;
   localparam int PWR  = 10;
   localparam int RSTW = 20;
   localparam int TXC  = 118 * QDIV;      // cycles per transaction

   logic clk_24 = 1'b0;
   logic reset_n;
   int   cyc = 0;

   sccb_config_if bus ();

   sccb_config #(.QDIV(QDIV), .PWR_WAIT(PWR), .RST_WAIT(RSTW), .DEV_ADDR(8'h42)) dut (
      .clk_24  (clk_24),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk_24 = ~clk_24;

   // Free-running edge counter used as the time base for all measurements
   always @(posedge clk_24) cyc++;

   // Monitor state (written only by the monitor)
   logic [26:0] tx_bits [32];
   logic [26:0] tx_oe   [32];
   int          tx_nb   [32];
   int          start_t [32];
   int          stop_t  [32];
   int          ntx = 0;
   int          proto_viol = 0;
   int          per_viol = 0;
   logic        prev_sioc = 1'b1, prev_line = 1'b1, line_v, first_rise = 1'b1;
   int          last_rise = 0;

   // Bus monitor: SIOD line with pull-up, start/stop detect, bit capture on SIOC rise
   always @(negedge clk_24) begin
      if (!reset_n) begin
         prev_sioc  = 1'b1;
         prev_line  = 1'b1;
         first_rise = 1'b1;
      end else begin
         line_v = bus.siod_oe ? bus.siod_out : 1'b1;
         if (bus.sioc && prev_sioc && prev_line && !line_v) begin
            if (ntx < 32) begin
               start_t[ntx] = cyc;
               tx_bits[ntx] = '0;
               tx_oe[ntx]   = '0;
               tx_nb[ntx]   = 0;
               stop_t[ntx]  = 0;
               ntx++;
            end
            first_rise = 1'b1;
         end else if (bus.sioc && prev_sioc && !prev_line && line_v) begin
            if (ntx > 0) stop_t[ntx-1] = cyc;
         end else if (line_v != prev_line && (bus.sioc || prev_sioc)) begin
            proto_viol++;
         end
         if (bus.sioc && !prev_sioc) begin
            if (!first_rise && (cyc - last_rise) != 4 * QDIV) per_viol++;
            first_rise = 1'b0;
            last_rise  = cyc;
            if (ntx > 0 && tx_nb[ntx-1] < 27) begin
               tx_bits[ntx-1] = {tx_bits[ntx-1][25:0], bus.siod_out};
               tx_oe[ntx-1]   = {tx_oe[ntx-1][25:0], bus.siod_oe};
               tx_nb[ntx-1]   = tx_nb[ntx-1] + 1;
            end
         end
         prev_sioc = bus.sioc;
         prev_line = line_v;
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Expected {sub-address, data} table, written out by hand
   logic [7:0] exp_sub [6] = '{8'h12, 8'h12, 8'h11, 8'h0C, 8'h3A, 8'h40};
   logic [7:0] exp_dat [6] = '{8'h80, 8'h00, 8'h01, 8'h00, 8'h04, 8'hC0};

   function automatic logic [26:0] exp_frame(input int i);
      return {8'h42, 1'b1, exp_sub[i], 1'b1, exp_dat[i], 1'b1};
   endfunction

   int   c0, d0, t_done, base, base2;
   logic got, pulsed;

   initial begin
      reset_n   = 1'b0;
      bus.start = 1'b0;
      repeat (3) @(negedge clk_24);
      chk("rst_sioc", bus.sioc, 1);
      chk("rst_siod", bus.siod_out, 1);
      chk("rst_oe",   bus.siod_oe, 1);
      chk("rst_busy", bus.busy, 1);
      chk("rst_done", bus.done, 0);

      // Run until bit 12 of entry 1 has been clocked, then hit reset
      reset_n = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk_24);
         if (ntx >= 2 && tx_nb[1] >= 13) begin got = 1'b1; break; end
      end
      chk("reach_entry1_bit12", got, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_sioc", bus.sioc, 1);
      chk("mid_rst_siod", bus.siod_out, 1);
      chk("mid_rst_oe",   bus.siod_oe, 1);
      chk("mid_rst_busy", bus.busy, 1);
      repeat (3) @(negedge clk_24);
      chk("mid_rst_done", bus.done, 0);

      // Full run; start is raised at release and again during transaction 3
      base      = ntx;
      c0        = cyc;
      reset_n   = 1'b1;
      bus.start = 1'b1;
      got       = 1'b0;
      pulsed    = 1'b0;
      t_done    = 0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk_24);
         bus.start = 1'b0;
         if (bus.done) begin got = 1'b1; t_done = cyc; break; end
         if (!pulsed && ntx >= base + 4 && tx_nb[base+3] >= 5) begin
            bus.start = 1'b1;
            pulsed    = 1'b1;
         end
      end
      chk("done_seen", got, 1);
      // First start falls on the first quarter tick after the power-up wait
      chk("first_start_time", start_t[base] - c0, PWR + QDIV);
      chk("done_time", t_done - c0, 6 * TXC + RSTW + PWR);
      chk("busy_at_done", bus.busy, 0);
      chk("tx_count", ntx - base, 6);
      chk("tx0_bits", tx_bits[base], 27'b01000010_1_00010010_1_10000000_1);
      chk("tx0_oe",   tx_oe[base],   27'b11111111_0_11111111_0_11111111_0);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("tx%0d_frame", i), tx_bits[base+i], exp_frame(i));
         chk($sformatf("tx%0d_nbits", i), tx_nb[base+i], 27);
      end
      // Stop rise to next start fall: q3 hold + 4 gap ticks + first start tick,
      // plus the settle delay after the soft-reset write
      chk("gap_0_1", start_t[base+1] - stop_t[base], 6 * QDIV + RSTW);
      for (int i = 1; i < 5; i++)
         chk($sformatf("gap_%0d_%0d", i, i + 1), start_t[base+i+1] - stop_t[base+i], 6 * QDIV);
      chk("proto_viol", proto_viol, 0);
      chk("sioc_period_viol", per_viol, 0);

      // Restart from DONE
      repeat (5) @(negedge clk_24);
      chk("done_hold", bus.done, 1);
      base2     = ntx;
      d0        = cyc;
      bus.start = 1'b1;
      @(negedge clk_24);
      bus.start = 1'b0;
      chk("restart_busy", bus.busy, 1);
      chk("restart_done", bus.done, 0);
      got    = 1'b0;
      t_done = 0;
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk_24);
         if (bus.done) begin got = 1'b1; t_done = cyc; break; end
      end
      chk("done2_seen", got, 1);
      chk("done2_time", t_done - d0, 1 + 6 * TXC + RSTW);
      chk("tx2_count", ntx - base2, 6);
      chk("run2_tx0", tx_bits[base2], exp_frame(0));
      chk("run2_tx5", tx_bits[base2+5], exp_frame(5));
      chk("run2_first_start", start_t[base2] - d0, 1 + QDIV);
      chk("proto_viol_end", proto_viol, 0);
      chk("sioc_period_viol_end", per_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
